if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch stage directly downstream of the program counter register.
//  Issues one instruction-memory request per PC value, tracks at most one outstanding request,
//  buffers returned {pc, instr} pairs for decode, and back-pressures the PC via pc_enable_out.
//  Flush discards queued and in-flight fetches (branch/jump redirect).
// PARAMETERS
//  DEPTH   2   queue entries of {pc,instr}; power of two, >=2
//  ADDR_W  32  PC / IM address width
//  DATA_W  32  instruction width
// PORTS
//  clk            in   1       single clock; all state on posedge clk
//  rst            in   1       asynchronous, active-high reset
//  pc_in          in   ADDR_W  current PC (PC register output)
//  im_read_in     in   1       PC register's fetch-request flag
//  pc_enable_out  out  1       to PC register: request accepted, PC may advance
//  im_req         out  1       IM read strobe, one cycle per request
//  im_addr        out  ADDR_W  IM address (= pc_in when im_req)
//  im_rdata       in   DATA_W  IM read data
//  im_rvalid      in   1       IM response valid, variable latency >=1 cycle
//  flush          in   1       discard all queued/in-flight fetches
//  id_valid       out  1       queue head valid to decode
//  id_pc          out  ADDR_W  PC of head entry
//  id_instr       out  DATA_W  instruction of head entry
//  id_ready       in   1       decode accepts head this cycle
// BEHAVIOUR
//  Reset (rst=1, async): state=IDLE, count=0, pointers=0, latched PC=0; all outputs 0;
//    im_req/pc_enable_out forced 0 while rst high.
//  FSM: IDLE, WAIT, DROP.
//  accept = (state==IDLE) & im_read_in & ~flush & (count<DEPTH); combinational.
//    im_req=accept, im_addr=pc_in, pc_enable_out=accept; accept: latch pc_in, IDLE->WAIT.
//  WAIT & im_rvalid & ~flush: push {latched pc, im_rdata}, ->IDLE. Next request earliest
//    next cycle (max 1 fetch per 2 cycles). Space guaranteed by accept check.
//  IDLE/DROP-exit: im_rvalid in IDLE ignored (stale response after reset).
//  Pop: id_valid & id_ready -> head advances; push+pop same cycle keeps count.
//  id_valid = (count!=0); id_pc/id_instr = head entry; 0 when empty.
//  Flush (priority over push/pop/accept): count=0, pointers=0 next cycle;
//    WAIT & ~im_rvalid -> DROP; WAIT & im_rvalid -> IDLE, data discarded; IDLE stays IDLE.
//  DROP: no requests; im_rvalid -> IDLE, data discarded; flush in DROP stays DROP.
//  Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
//  Reset mid-WAIT: returns to IDLE, pending response ignored.
// CONFIGURATION
//  IF_BYPASS_EN defined: when queue empty, state WAIT, im_rvalid, ~flush: id_valid=1
//    same cycle with id_pc=latched pc, id_instr=im_rdata. If id_ready, not pushed;
//    otherwise pushed as normal.
//  Undefined: response always enters queue; id_valid earliest cycle after im_rvalid.
// STRUCTURE
//  Package if_pkg: fetch_entry_t struct {pc, instr}; fetch_state_e enum {IDLE,WAIT,DROP};
//    IF_DEPTH default constant.
//  Sub-module fetch_fifo: DEPTH-entry register FIFO of fetch_entry_t
//    (push, pop, clear, count, head); FSM and handshake stay in if_fetch_queue.
// TESTING
//  Reset: rst=1 with im_read_in=1, im_rvalid=1 -> all outputs 0; after release count=0, IDLE.
//  Single fetch: pc_in=0x100, im_read_in=1 -> im_req=1, im_addr=0x100, pc_enable_out=1;
//    im_rvalid 2 cycles later with 0x00000013 -> id_valid, id_pc=0x100, id_instr=0x13
//    next cycle.
//  Full: id_ready=0, fetch 0x0, 0x4 -> count=2; third request: im_req=0, pc_enable_out=0;
//    id_ready=1 one cycle pops 0x0, request resumes next cycle.
//  Flush in WAIT: flush, then im_rvalid=1 3 cycles later, data 0xDEAD -> id_valid stays 0;
//    new request accepted cycle after im_rvalid.
//  Flush with im_rvalid same cycle and 1 queued entry -> both discarded, IDLE next cycle,
//    id_valid=0.
//  IF_BYPASS_EN: empty queue, id_ready=1, im_rvalid with 0x00A00093 -> id_valid same cycle,
//    count stays 0.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared types and defaults for the instruction-fetch queue
package if_pkg;
  localparam int IF_DEPTH = 2;
  localparam int IF_ADDR_W = 32;
  localparam int IF_DATA_W = 32;
  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } fetch_entry_t;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry register FIFO of fetch entries with synchronous clear
module fetch_fifo import if_pkg::*; #(
  parameter int DEPTH = IF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output logic [AW:0]  count,
  output fetch_entry_t head
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wp] <= din;
  end
  assign head = (count != '0) ? mem[rp] : '0;
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch stage with one outstanding IM request and a {pc,instr} queue to decode
// Optional same-cycle response bypass to decode when the queue is empty: define IF_BYPASS_EN.
module if_fetch_queue import if_pkg::*; #(
  parameter int DEPTH = IF_DEPTH,
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              im_read_in,
  output logic              pc_enable_out,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_rdata,
  input  logic              im_rvalid,
  input  logic              flush,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr,
  input  logic              id_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state;
  logic [ADDR_W-1:0] pc_q;
  logic [CW-1:0] count;
  fetch_entry_t head;
  logic accept, resp, byp, push, pop, nonempty;
  assign nonempty = count != '0;
  assign accept = state == IDLE && im_read_in && !flush && count < CW'(DEPTH);
  assign resp = state == WAIT && im_rvalid && !flush;
`ifdef IF_BYPASS_EN
  assign byp = resp && !nonempty;
`else
  assign byp = 1'b0;
`endif
  assign push = resp && !(byp && id_ready);
  assign pop = nonempty && id_ready && !flush;
  // request outputs are gated combinationally so they read 0 throughout reset
  assign im_req = accept && !rst;
  assign pc_enable_out = accept && !rst;
  assign im_addr = rst ? '0 : pc_in;
  assign id_valid = nonempty || byp;
  assign id_pc = byp ? pc_q : head.pc;
  assign id_instr = byp ? im_rdata : head.instr;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .clear(flush),
    .din('{pc: pc_q, instr: im_rdata}),
    .count(count),
    .head(head)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= WAIT;
          pc_q <= pc_in;
        end
        WAIT: state <= im_rvalid ? IDLE : flush ? DROP : WAIT;
        DROP: state <= im_rvalid ? IDLE : DROP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed vector table, reset corner sequences and randomized model check
module tb_if_fetch_queue;
`ifdef IF_BYPASS_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1;
  logic [31:0] pc_in = 0, im_addr, im_rdata = 0, id_pc, id_instr;
  logic im_read_in = 0, pc_enable_out, im_req, im_rvalid = 0, flush = 0, id_valid, id_ready = 0;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  if_fetch_queue dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .im_read_in(im_read_in), .pc_enable_out(pc_enable_out),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_rvalid(im_rvalid), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
  );
  typedef struct {
    logic rd; logic [31:0] pc; logic rv; logic [31:0] dat; logic fl; logic rdy;
    logic req; logic vld; logic [31:0] epc; logic [31:0] ein;
  } vec_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  vec_t tbl [$];
  ent_t q [$];
  bit outst, drop;
  logic [31:0] lpc;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    else pass++;
  endtask
  function automatic vec_t mk(logic rd, logic [31:0] pc, logic rv, logic [31:0] dat, logic fl,
                              logic rdy, logic req, logic vld, logic [31:0] epc, logic [31:0] ein);
    vec_t v;
    v.rd = rd; v.pc = pc; v.rv = rv; v.dat = dat; v.fl = fl; v.rdy = rdy;
    v.req = req; v.vld = vld; v.epc = epc; v.ein = ein;
    return v;
  endfunction
  task automatic drive(input logic rd, input logic [31:0] pc, input logic rv, input logic [31:0] dat,
                       input logic fl, input logic rdy);
    @(negedge clk);
    im_read_in = rd; pc_in = pc; im_rvalid = rv; im_rdata = dat; flush = fl; id_ready = rdy;
    #1;
  endtask
  task automatic outs(input string n, input logic req, input logic vld, input logic [31:0] p,
                      input logic [31:0] ins);
    chk({n, ".im_req"}, 64'(im_req), 64'(req));
    chk({n, ".pc_enable_out"}, 64'(pc_enable_out), 64'(req));
    chk({n, ".id_valid"}, 64'(id_valid), 64'(vld));
    chk({n, ".id_pc"}, 64'(id_pc), 64'(p));
    chk({n, ".id_instr"}, 64'(id_instr), 64'(ins));
    if (req) chk({n, ".im_addr"}, 64'(im_addr), 64'(pc_in));
  endtask
  initial begin
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h13, 0, 0, 0, B, B ? 32'h100 : 0, B ? 32'h13 : 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h100, 32'h13));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'hA0, 0, 0, 0, B, 0, B ? 32'hA0 : 0));
    tbl.push_back(mk(1, 32'h4, 0, 0, 0, 0, 1, 1, 0, 32'hA0));
    tbl.push_back(mk(0, 0, 1, 32'hA4, 0, 0, 0, 1, 0, 32'hA0));
    tbl.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 32'hA0));
    tbl.push_back(mk(1, 32'h8, 0, 0, 0, 1, 0, 1, 0, 32'hA0));
    tbl.push_back(mk(1, 32'h8, 0, 0, 0, 0, 1, 1, 32'h4, 32'hA4));
    tbl.push_back(mk(0, 0, 1, 32'hA8, 1, 0, 0, 1, 32'h4, 32'hA4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'hC, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 1, 32'hDEAD, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h77, 0, 1, 0, B, B ? 32'h10 : 0, B ? 32'h77 : 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, !B, B ? 0 : 32'h10, B ? 0 : 32'h77));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    im_read_in = 1; im_rvalid = 1; pc_in = 32'h55; im_rdata = 32'h66;
    #2;
    outs("reset", 0, 0, 0, 0);
    chk("reset.im_addr", 64'(im_addr), 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 0;
    #1;
    outs("post_reset", 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].pc, tbl[i].rv, tbl[i].dat, tbl[i].fl, tbl[i].rdy);
      outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].vld, tbl[i].epc, tbl[i].ein);
    end
    drive(1, 32'h20, 0, 0, 0, 0);
    outs("midwait.req", 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1;
    #1;
    outs("midwait.rst", 0, 0, 0, 0);
    drive(1, 32'h24, 1, 32'h55, 0, 0);
    rst = 0;
    #1;
    outs("midwait.stale", 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    outs("midwait.after", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 0;
    q.delete(); outst = 0; drop = 0; lpc = 0;
    for (int c = 0; c < 3000; c++) begin
      logic rd, rv, fl, rdy, acc, byp;
      logic [31:0] pc, dat;
      rd = $urandom_range(3) != 0;
      rv = outst ? $urandom_range(2) == 0 : $urandom_range(3) == 0;
      fl = $urandom_range(15) == 0;
      rdy = $urandom_range(1) == 1;
      pc = {$urandom_range(255), 2'b00};
      dat = $urandom;
      drive(rd, pc, rv, dat, fl, rdy);
      acc = !outst && rd && !fl && q.size() < DEPTH;
      byp = B && q.size() == 0 && outst && !drop && rv && !fl;
      outs($sformatf("rand%0d", c), acc, q.size() > 0 || byp,
           q.size() > 0 ? q[0].pc : byp ? lpc : 0, q.size() > 0 ? q[0].ins : byp ? dat : 0);
      if (fl) begin
        q.delete();
        if (outst && !rv) drop = 1;
        if (outst && rv) begin outst = 0; drop = 0; end
      end else begin
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (outst && rv) begin
          if (!drop && !(byp && rdy)) q.push_back('{pc: lpc, ins: dat});
          outst = 0; drop = 0;
        end
        if (acc) begin outst = 1; lpc = pc; end
      end
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
